// File: rtl/adam_aes_key_expansion_multi_if.sv
// Bus between the AES register file and the iterative key schedule.
// ADAM_AES_KEYEXP_ZEROIZE_EN adds the zeroize input.
interface adam_aes_key_expansion_multi_if;
   logic [255:0] key;
   logic         keylen;
   logic         init;
   logic         busy;
   logic         ready;
   logic [3:0]   num_rounds;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
`ifdef ADAM_AES_KEYEXP_ZEROIZE_EN
   logic         zeroize;
`endif

   modport master (
      output key, keylen, init, rk_idx,
`ifdef ADAM_AES_KEYEXP_ZEROIZE_EN
      output zeroize,
`endif
      input  busy, ready, num_rounds, rk_data
   );

   modport slave (
      input  key, keylen, init, rk_idx,
`ifdef ADAM_AES_KEYEXP_ZEROIZE_EN
      input  zeroize,
`endif
      output busy, ready, num_rounds, rk_data
   );
endinterface

// File: rtl/adam_aes_key_expansion_multi.sv
// Iterative AES-128/AES-256 key schedule, one word per cycle, indexed round-key read.
// ADAM_AES_KEYEXP_ZEROIZE_EN adds a zeroize input that clears the store.
module adam_aes_key_expansion_multi #(
   parameter bit AES256_EN  = 1'b1,
   parameter bit RK_REG_OUT = 1'b1
) (
   input logic clk,
   input logic reset,
   adam_aes_key_expansion_multi_if.slave bus
);
   localparam int unsigned NW = AES256_EN ? 60 : 44;

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t       state_q, state_d;
   logic [31:0]  w [NW];
   logic [5:0]   idx_q;
   logic [7:0]   rcon_q;
   logic         mode_q;
   logic         ready_q;
   logic         busy, load, step, done, zero;
   logic [5:0]   nk, last;
   logic [31:0]  prev, back, sin, sout, temp, new_word;
   logic         rot_hit, sub_hit;
   logic [5:0]   rd_base;
   logic [127:0] rd_word;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse as b^254 by repeated squaring (b=0 maps to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] p, inv;
      p   = b;
      inv = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

`ifdef ADAM_AES_KEYEXP_ZEROIZE_EN
   assign zero = bus.zeroize;
`else
   assign zero = 1'b0;
`endif

   assign nk   = mode_q ? 6'd8 : 6'd4;
   assign last = mode_q ? 6'd59 : 6'd43;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.init) state_d = EXPAND;
         EXPAND:  if (idx_q == last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (zero) state_d = IDLE;
   end

   always_comb begin
      busy = (state_q == EXPAND);
      load = (state_q == IDLE) && bus.init && !zero;
      step = (state_q == EXPAND) && !zero;
      done = step && (idx_q == last);
   end

   // One shared 4-byte S-box: RotWord is applied on its input only on Nk boundaries.
   always_comb begin
      prev     = w[idx_q - 6'd1];
      back     = w[idx_q - nk];
      rot_hit  = mode_q ? (idx_q[2:0] == 3'd0) : (idx_q[1:0] == 2'd0);
      sub_hit  = mode_q && (idx_q[2:0] == 3'd4);
      sin      = rot_hit ? {prev[23:0], prev[31:24]} : prev;
      sout     = {sbox(sin[31:24]), sbox(sin[23:16]), sbox(sin[15:8]), sbox(sin[7:0])};
      temp     = rot_hit ? (sout ^ {rcon_q, 24'h0}) : (sub_hit ? sout : prev);
      new_word = back ^ temp;
   end

   always_ff @(posedge clk) begin
      if (reset) mode_q <= 1'b0;
      else if (load) mode_q <= AES256_EN && bus.keylen;
   end

   always_ff @(posedge clk) begin
      if (reset || zero) begin
         for (int unsigned i = 0; i < NW; i++) w[i] <= '0;
         idx_q   <= '0;
         rcon_q  <= '0;
         ready_q <= 1'b0;
      end else if (load) begin
         for (int unsigned i = 0; i < 8; i++)
            if ((AES256_EN && bus.keylen) || i < 4) w[i] <= bus.key[255 - 32*i -: 32];
         idx_q   <= (AES256_EN && bus.keylen) ? 6'd8 : 6'd4;
         rcon_q  <= 8'h01;
         ready_q <= 1'b0;
      end else if (step) begin
         w[idx_q] <= new_word;
         idx_q    <= idx_q + 6'd1;
         if (rot_hit) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
         if (done) ready_q <= 1'b1;
      end
   end

   assign bus.busy       = busy;
   assign bus.ready      = ready_q;
   assign bus.num_rounds = mode_q ? 4'd14 : 4'd10;

   always_comb begin
      rd_base = {bus.rk_idx, 2'b00};
      rd_word = '0;
      if (bus.rk_idx <= bus.num_rounds)
         rd_word = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
   end

   generate
      if (RK_REG_OUT) begin : g_rk_reg
         logic [127:0] rk_q;
         always_ff @(posedge clk) begin
            if (reset || zero) rk_q <= '0;
            else               rk_q <= rd_word;
         end
         assign bus.rk_data = rk_q;
      end else begin : g_rk_comb
         assign bus.rk_data = rd_word;
      end
   endgenerate
endmodule

// File: tb/tb_adam_aes_key_expansion_multi.sv
// Self-checking bench for adam_aes_key_expansion_multi against a FIPS-197 key expansion model.
// Define ADAM_AES_KEYEXP_ZEROIZE_EN to exercise the zeroize input.
module tb_adam_aes_key_expansion_multi;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   adam_aes_key_expansion_multi_if bus ();

   adam_aes_key_expansion_multi #(.AES256_EN(1'b1), .RK_REG_OUT(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  sb [256];
   logic [7:0]  rcon_tab [10];
   logic [31:0] mw [60];
   int          m_nr;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod ^= 15'(a) << i;
      for (int i = 14; i >= 8; i--) if (prod[i]) prod ^= 15'h11b << (i - 8);
      return prod[7:0];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x] = s;
      end
      rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   function automatic logic [31:0] subw(input logic [31:0] v);
      return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
   endfunction

   task automatic model(input logic [255:0] k, input bit m256);
      int nk;
      logic [31:0] t;
      nk   = m256 ? 8 : 4;
      m_nr = m256 ? 14 : 10;
      for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4*(m_nr+1); i++) begin
         t = mw[i-1];
         if (i % nk == 0)                t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
         else if (nk == 8 && i % 8 == 4) t = subw(t);
         mw[i] = mw[i-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int r);
      if (r > m_nr) return '0;
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   task automatic read_rk(input int r, output logic [127:0] d);
      @(negedge clk);
      bus.rk_idx = 4'(r);
      @(negedge clk);
      d = bus.rk_data;
   endtask

   task automatic start_exp(input logic [255:0] k, input logic kl);
      @(negedge clk);
      bus.key    = k;
      bus.keylen = kl;
      bus.init   = 1'b1;
      @(negedge clk);
      bus.init   = 1'b0;
   endtask

   task automatic wait_ready(input int start, output int cyc);
      cyc = start;
      while (!bus.ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic check_all(input string tag);
      logic [127:0] d;
      for (int r = 0; r < 16; r++) begin
         read_rk(r, d);
         check($sformatf("%s_rk%0d", tag, r), d, exp_rk(r));
      end
   endtask

   initial begin
      logic [127:0] d;
      logic [255:0] k, k2;
      int cyc;
      bit kl;

      build_tables();
      bus.key = '0; bus.keylen = 1'b0; bus.init = 1'b0; bus.rk_idx = '0;
`ifdef ADAM_AES_KEYEXP_ZEROIZE_EN
      bus.zeroize = 1'b0;
`endif
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_ready", 128'(bus.ready), 128'd0);
      check("rst_nr", 128'(bus.num_rounds), 128'd10);
      check("rst_rk", bus.rk_data, 128'd0);

      // AES-128 reference vector
      start_exp(K128, 1'b0);
      check("a128_busy", 128'(bus.busy), 128'd1);
      wait_ready(1, cyc);
      check("a128_lat", 128'(cyc), 128'd41);
      check("a128_nr", 128'(bus.num_rounds), 128'd10);
      read_rk(1, d);  check("a128_v1", d, 128'ha0fafe1788542cb123a339392a6c7605);
      read_rk(10, d); check("a128_v10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      model(K128, 1'b0); check_all("a128");

      // AES-256 reference vector
      start_exp(K256, 1'b1);
      check("a256_ready_drop", 128'(bus.ready), 128'd0);
      wait_ready(1, cyc);
      check("a256_lat", 128'(cyc), 128'd53);
      check("a256_nr", 128'(bus.num_rounds), 128'd14);
      read_rk(14, d); check("a256_v14", d, 128'hfe4890d1e6188d0b046df344706c631e);
      model(K256, 1'b1); check_all("a256");

      // init while busy is ignored
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++) k2[32*i +: 32] = $urandom;
      start_exp(k, 1'b0);
      repeat (18) @(negedge clk);
      bus.key = k2; bus.keylen = 1'b1; bus.init = 1'b1;
      @(negedge clk);
      bus.init = 1'b0;
      wait_ready(20, cyc);
      check("rein_lat", 128'(cyc), 128'd41);
      check("rein_nr", 128'(bus.num_rounds), 128'd10);
      model(k, 1'b0); check_all("rein");

      // reset during AES-256 expansion
      start_exp(K256, 1'b1);
      repeat (28) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mrst_busy", 128'(bus.busy), 128'd0);
      check("mrst_ready", 128'(bus.ready), 128'd0);
      check("mrst_rk", bus.rk_data, 128'd0);
      start_exp(K256, 1'b1);
      wait_ready(1, cyc);
      check("mrst_lat", 128'(cyc), 128'd53);
      model(K256, 1'b1); check_all("mrst");

      // back-to-back AES-256 then AES-128
      start_exp(K128, 1'b0);
      check("b2b_ready_drop", 128'(bus.ready), 128'd0);
      wait_ready(1, cyc);
      check("b2b_lat", 128'(cyc), 128'd41);
      check("b2b_nr", 128'(bus.num_rounds), 128'd10);
      read_rk(10, d); check("b2b_v10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // randomized keys and modes
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
         kl = 1'($urandom_range(0, 1));
         start_exp(k, kl);
         wait_ready(1, cyc);
         check($sformatf("rnd%0d_lat", n), 128'(cyc), kl ? 128'd53 : 128'd41);
         model(k, kl);
         check($sformatf("rnd%0d_nr", n), 128'(bus.num_rounds), 128'(m_nr));
         check_all($sformatf("rnd%0d", n));
      end

`ifdef ADAM_AES_KEYEXP_ZEROIZE_EN
      @(negedge clk);
      bus.key = K256; bus.keylen = 1'b1; bus.init = 1'b1; bus.zeroize = 1'b1;
      @(negedge clk);
      bus.init = 1'b0; bus.zeroize = 1'b0;
      check("zer_ready", 128'(bus.ready), 128'd0);
      check("zer_busy", 128'(bus.busy), 128'd0);
      for (int r = 0; r < 16; r++) begin
         read_rk(r, d);
         check($sformatf("zer_rk%0d", r), d, 128'd0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
